ff_arbiter: RTL and testbench
=============================

FF_ARBITER -- requirements
Module: ff_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: data width of the shared register.
REQ-002 The block SHALL have parameter NREQ, default 4 (legal 2..8): number of requesters.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_i, input, NREQ bits: request from requester n; held until granted.
REQ-006 The block SHALL have port data_i, input, NREQ*WIDTH bits: requester n data at bits [n*WIDTH +: WIDTH].
REQ-007 The block SHALL have port gnt_o, output, NREQ bits: one-hot, combinational; requester n's data is captured this cycle.
REQ-008 The block SHALL have port data_o, output, WIDTH bits: contents of the shared register.
REQ-009 The block SHALL have port owner_o, output, $clog2(NREQ) bits: index of the requester whose data is in the register.
REQ-010 The block SHALL have port valid_o, output, 1 bit: data_o/owner_o hold an unconsumed value.
REQ-011 The block SHALL have port ready_i, input, 1 bit: consumer accepts data_o when valid_o && ready_i.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE (valid_o=0) and HOLD (valid_o=1).
REQ-013 The block SHALL define the load slot as: state IDLE, or state HOLD with ready_i=1.
REQ-014 In a load slot with any req_i bit set, the block SHALL assert exactly one gnt_o bit, selected round-robin.
REQ-015 Round-robin selection SHALL choose the first set req_i bit at or above pointer ptr, wrapping from NREQ-1 to 0.
REQ-016 On a grant to n, the block SHALL, at the next edge, load data_i slice n into the register, set owner_o=n, set ptr=(n+1) mod NREQ and enter HOLD.
REQ-017 gnt_o SHALL be all-zero outside load slots, when no request is pending, and while rst=1.
REQ-018 In HOLD with ready_i=0, the register, owner_o, ptr and state SHALL be held unchanged regardless of req_i.
REQ-019 In HOLD with ready_i=1 and no request pending, the block SHALL enter IDLE; the register and owner_o SHALL retain their values.
REQ-020 In HOLD with ready_i=1 and a request pending, the block SHALL consume and reload in the same cycle, staying in HOLD; sustained throughput is one transfer per cycle.
REQ-021 Grant-to-valid latency SHALL be one cycle: valid_o rises on the edge that captures the granted data.
REQ-022 ready_i SHALL be ignored in IDLE.
REQ-023 req_i deasserted before grant SHALL be dropped without side effects; ptr SHALL advance only on a grant.

Reset
REQ-024 When rst=1 at a rising edge, the block SHALL set state=IDLE, ptr=0, register=0, owner_o=0 and valid_o=0.
REQ-025 Reset asserted in HOLD SHALL discard the held value without a handshake; rst SHALL override any concurrent grant or consume.
REQ-026 In the first cycle after rst deasserts, the block SHALL be able to grant.

Structure
REQ-027 Package ff_arbiter_pkg SHALL hold the FSM state enum (IDLE, HOLD) and the default NREQ/WIDTH constants.
REQ-028 Round-robin selection SHALL be a sub-module rr_pick (inputs req, ptr; output one-hot gnt, index), purely combinational.
REQ-029 State, ptr, register and owner SHALL each be a single flop group with synchronous reset; there SHALL be no latches.

Verification
REQ-030 Reset then req_i=0001, data0=4'hA, ready_i=0 -> gnt_o=0001 for one cycle; next cycle valid_o=1, data_o=A, owner_o=0; holds until ready_i=1.
REQ-031 req_i=1111 held, ready_i=1 continuously, distinct data per requester -> owners 0,1,2,3,0 on consecutive cycles, valid_o continuously 1.
REQ-032 ptr=3 with req_i=1001 -> grant to 3 then 0 (wrap); req_i=0101 after owner 2 -> grant to 0 before 2.
REQ-033 HOLD, ready_i=0, req_i toggling -> gnt_o=0, data_o/owner_o/ptr stable across 5 cycles.
REQ-034 rst=1 in HOLD coincident with ready_i=1 and req_i=0010 -> next cycle valid_o=0, data_o=0, owner_o=0, no grant taken; following cycle grants 1.
REQ-035 Single requester 2, ready_i=1 pulsed every other cycle -> valid_o alternates correctly; no duplicate or lost transfers (scoreboard).

Source files
------------

// File: rtl/ff_arbiter_pkg.sv
// Purpose   : shared types and default sizes for the ff_arbiter block.
// Latency   : n/a (declarations only).
// Backpress : n/a.
// Contents  : state_e (IDLE/HOLD), DEF_NREQ, DEF_WIDTH.
package ff_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,   // register empty, valid_o low
      HOLD = 1'b1    // register holds an unconsumed value
   } state_e;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/ff_arbiter_rr_pick.sv
// Purpose   : round-robin pick of the first set request at or above ptr, wrapping.
// Latency   : purely combinational.
// Backpress : none; the caller decides whether the pick is used.
// Ports     : req_i  - request vector
//             ptr_i  - highest-priority index this cycle
//             gnt_o  - one-hot pick (all-zero when req_i is zero)
//             idx_o  - binary index of the pick (0 when nothing picked)
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IW-1:0]   idx_o
);

   always_comb begin
      int  cand;
      logic found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = 0;
      // Walk NREQ positions starting at ptr; the first hit wins.
      for (int i = 0; i < NREQ; i++) begin
         cand = (int'(ptr_i) + i) % NREQ;
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/ff_arbiter.sv
// Purpose   : round-robin arbiter feeding one shared data register with valid/ready output.
// Latency   : grant is combinational; valid_o rises on the edge that captures the granted data.
// Backpress : ready_i low in HOLD freezes register, owner, ptr and suppresses all grants.
// Ports     : clk, rst (sync, active-high); req_i/data_i from requesters; gnt_o one-hot grant;
//             data_o/owner_o/valid_o shared register contents; ready_i consumer accept.
module ff_arbiter
   import ff_arbiter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = DEF_NREQ
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_i,
   input  logic [NREQ*WIDTH-1:0]   data_i,
   output logic [NREQ-1:0]         gnt_o,
   output logic [WIDTH-1:0]        data_o,
   output logic [$clog2(NREQ)-1:0] owner_o,
   output logic                    valid_o,
   input  logic                    ready_i
);

   localparam int IW = $clog2(NREQ);

   state_e           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [IW-1:0]    owner_q, owner_d;

   logic [NREQ-1:0]  pick_gnt;
   logic [IW-1:0]    pick_idx;
   logic             load_slot;
   logic             any_req;
   logic             take;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx)
   );

   // Register may be (re)loaded when empty, or when the current value is consumed now.
   assign load_slot = (state_q == IDLE) || ready_i;
   assign any_req   = |req_i;
   // rst gates the grant so nothing looks taken during a reset cycle.
   assign take      = load_slot && any_req && !rst;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = HOLD;
         HOLD:    if (ready_i) state_d = any_req ? HOLD : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      valid_o = (state_q == HOLD);
      gnt_o   = take ? pick_gnt : '0;
   end

   // Datapath next state; owner/data persist after consumption until overwritten.
   always_comb begin
      ptr_d   = ptr_q;
      data_d  = data_q;
      owner_d = owner_q;
      if (take) begin
         data_d  = data_i[int'(pick_idx)*WIDTH +: WIDTH];
         owner_d = pick_idx;
         if (int'(pick_idx) == NREQ-1) ptr_d = '0;
         else                          ptr_d = pick_idx + IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   always_ff @(posedge clk) begin
      if (rst) data_q <= '0;
      else     data_q <= data_d;
   end

   always_ff @(posedge clk) begin
      if (rst) owner_q <= '0;
      else     owner_q <= owner_d;
   end

   assign data_o  = data_q;
   assign owner_o = owner_q;

endmodule

// File: tb/tb_ff_arbiter.sv
// Purpose   : directed self-checking bench for ff_arbiter (NREQ=4, WIDTH=4).
// Latency   : inputs change 1ns after the rising edge; outputs sampled before the next edge.
// Backpress : ready_i driven per scenario.
module tb_ff_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_i;
   logic [15:0] data_i;
   logic [3:0]  gnt_o;
   logic [3:0]  data_o;
   logic [1:0]  owner_o;
   logic        valid_o;
   logic        ready_i;

   int n_cmp;
   int n_bad;

   ff_arbiter #(.WIDTH(4), .NREQ(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req_i   (req_i),
      .data_i  (data_i),
      .gnt_o   (gnt_o),
      .data_o  (data_o),
      .owner_o (owner_o),
      .valid_o (valid_o),
      .ready_i (ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_i = '0; ready_i = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_i = 4'b1111; ready_i = 1'b1;
      settle();
      n_cmp++; if (gnt_o !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt_o); end
      step(); step();
      settle();
      n_cmp++; if (gnt_o !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt2: got %b want 0000", gnt_o); end
      n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
      n_cmp++; if (data_o !== 4'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", data_o); end
      n_cmp++; if (owner_o !== 2'd0) begin n_bad++; $display("FAIL reset_owner: got %0d want 0", owner_o); end
      rst = 1'b0; req_i = '0; ready_i = 1'b0;
      step();
   endtask

   // IDLE, ptr=0: single grant, hold under ready=0, then drain to IDLE.
   task automatic test_single();
      req_i = 4'b0001; ready_i = 1'b0;
      settle();
      n_cmp++; if (gnt_o !== 4'b0001) begin n_bad++; $display("FAIL single_gnt: got %b want 0001", gnt_o); end
      step();
      req_i = 4'b0000;
      settle();
      n_cmp++; if (gnt_o !== 4'b0000) begin n_bad++; $display("FAIL single_gnt_off: got %b want 0000", gnt_o); end
      for (int c = 0; c < 3; c++) begin
         n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL single_valid c%0d: got %b want 1", c, valid_o); end
         n_cmp++; if (data_o !== 4'hA) begin n_bad++; $display("FAIL single_data c%0d: got %h want a", c, data_o); end
         n_cmp++; if (owner_o !== 2'd0) begin n_bad++; $display("FAIL single_owner c%0d: got %0d want 0", c, owner_o); end
         step();
      end
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      settle();
      n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL single_drain_valid: got %b want 0", valid_o); end
      n_cmp++; if (data_o !== 4'hA) begin n_bad++; $display("FAIL single_retain_data: got %h want a", data_o); end
   endtask

   // All four requesting, ready always high: owners 0,1,2,3,0 back to back.
   task automatic test_back_to_back();
      logic [1:0] exp_owner;
      logic [3:0] exp_gnt;
      logic [3:0] exp_data;
      do_reset();
      req_i = 4'b1111; ready_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         exp_owner = 2'(k % 4);
         exp_gnt   = 4'b0001 << exp_owner;
         exp_data  = 4'hA + 4'(exp_owner);
         settle();
         n_cmp++; if (gnt_o !== exp_gnt) begin n_bad++; $display("FAIL b2b_gnt k%0d: got %b want %b", k, gnt_o, exp_gnt); end
         step();
         n_cmp++; if (owner_o !== exp_owner) begin n_bad++; $display("FAIL b2b_owner k%0d: got %0d want %0d", k, owner_o, exp_owner); end
         n_cmp++; if (data_o !== exp_data) begin n_bad++; $display("FAIL b2b_data k%0d: got %h want %h", k, data_o, exp_data); end
         n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_valid k%0d: got %b want 1", k, valid_o); end
      end
      req_i = '0;
      step();
   endtask

   // Pointer wrap 3 -> 0, and requester 0 beats 2 when ptr sits at 3.
   task automatic test_wrap();
      do_reset();
      req_i = 4'b0100; ready_i = 1'b1;
      step();                          // owner 2, ptr 3
      req_i = 4'b1001;
      settle();
      n_cmp++; if (gnt_o !== 4'b1000) begin n_bad++; $display("FAIL wrap_gnt3: got %b want 1000", gnt_o); end
      step();
      n_cmp++; if (owner_o !== 2'd3) begin n_bad++; $display("FAIL wrap_owner3: got %0d want 3", owner_o); end
      req_i = 4'b0001;
      settle();
      n_cmp++; if (gnt_o !== 4'b0001) begin n_bad++; $display("FAIL wrap_gnt0: got %b want 0001", gnt_o); end
      step();                          // owner 0, ptr 1
      req_i = 4'b0100;
      step();                          // owner 2, ptr 3
      n_cmp++; if (owner_o !== 2'd2) begin n_bad++; $display("FAIL wrap_owner2: got %0d want 2", owner_o); end
      req_i = 4'b0101;
      settle();
      n_cmp++; if (gnt_o !== 4'b0001) begin n_bad++; $display("FAIL wrap_0_before_2: got %b want 0001", gnt_o); end
      step();
      n_cmp++; if (data_o !== 4'hA) begin n_bad++; $display("FAIL wrap_data0: got %h want a", data_o); end
      req_i = 4'b0100;
      settle();
      n_cmp++; if (gnt_o !== 4'b0100) begin n_bad++; $display("FAIL wrap_gnt2: got %b want 0100", gnt_o); end
      step();                          // owner 2, ptr 3
      req_i = '0;
      step();                          // IDLE
   endtask

   // HOLD with ready low: req_i toggles but nothing moves; ptr proven unchanged afterwards.
   task automatic test_hold_stall();
      logic [3:0] pat [5];
      pat = '{4'b1111, 4'b0000, 4'b0101, 4'b1010, 4'b1111};
      req_i = 4'b0010; ready_i = 1'b0;
      step();                          // owner 1, ptr 2
      for (int c = 0; c < 5; c++) begin
         req_i = pat[c];
         settle();
         n_cmp++; if (gnt_o !== 4'b0000) begin n_bad++; $display("FAIL stall_gnt c%0d: got %b want 0000", c, gnt_o); end
         step();
         n_cmp++; if (data_o !== 4'hB || owner_o !== 2'd1 || valid_o !== 1'b1)
            begin n_bad++; $display("FAIL stall_hold c%0d: got d=%h o=%0d v=%b want d=b o=1 v=1", c, data_o, owner_o, valid_o); end
      end
      req_i = 4'b1111; ready_i = 1'b1;
      settle();
      n_cmp++; if (gnt_o !== 4'b0100) begin n_bad++; $display("FAIL stall_ptr: got %b want 0100", gnt_o); end
      step();                          // owner 2, ptr 3
      req_i = '0;
      step();
   endtask

   // Reset in HOLD with a concurrent consume and request: reset wins.
   task automatic test_reset_in_hold();
      req_i = 4'b0001; ready_i = 1'b0;
      step();                          // owner 0 from ptr 3, HOLD
      rst = 1'b1; ready_i = 1'b1; req_i = 4'b0010;
      settle();
      n_cmp++; if (gnt_o !== 4'b0000) begin n_bad++; $display("FAIL rsthold_gnt: got %b want 0000", gnt_o); end
      step();
      rst = 1'b0;
      settle();
      n_cmp++; if (valid_o !== 1'b0 || data_o !== 4'h0 || owner_o !== 2'd0)
         begin n_bad++; $display("FAIL rsthold_clear: got v=%b d=%h o=%0d want v=0 d=0 o=0", valid_o, data_o, owner_o); end
      n_cmp++; if (gnt_o !== 4'b0010) begin n_bad++; $display("FAIL rsthold_regrant: got %b want 0010", gnt_o); end
      step();
      n_cmp++; if (owner_o !== 2'd1 || data_o !== 4'hB || valid_o !== 1'b1)
         begin n_bad++; $display("FAIL rsthold_load: got v=%b d=%h o=%0d want v=1 d=b o=1", valid_o, data_o, owner_o); end
      req_i = '0;
      step();
   endtask

   // Requester 2 alone, ready every other cycle, scoreboard of produced vs consumed values.
   task automatic test_pulsed();
      logic [3:0] sb [$];
      logic [3:0] exp_d;
      logic       exp_valid;
      logic       exp_gnt;
      int         k;
      int         consumed;
      do_reset();
      exp_valid = 1'b0;
      k = 0;
      consumed = 0;
      for (int c = 0; c < 24; c++) begin
         ready_i = c[0];
         req_i   = (k < 6) ? 4'b0100 : 4'b0000;
         data_i[11:8] = 4'(k * 3 + 1);
         settle();
         exp_gnt = (k < 6) && (!exp_valid || ready_i);
         n_cmp++; if (valid_o !== exp_valid) begin n_bad++; $display("FAIL pulse_valid c%0d: got %b want %b", c, valid_o, exp_valid); end
         n_cmp++; if (gnt_o !== (exp_gnt ? 4'b0100 : 4'b0000)) begin n_bad++; $display("FAIL pulse_gnt c%0d: got %b want %b", c, gnt_o, exp_gnt); end
         if (exp_valid && ready_i) begin
            exp_d = (sb.size() > 0) ? sb.pop_front() : 4'hx;
            consumed++;
            n_cmp++; if (data_o !== exp_d || owner_o !== 2'd2)
               begin n_bad++; $display("FAIL pulse_xfer c%0d: got d=%h o=%0d want d=%h o=2", c, data_o, owner_o, exp_d); end
         end
         if (exp_gnt) begin
            sb.push_back(4'(k * 3 + 1));
            k++;
         end
         exp_valid = exp_gnt ? 1'b1 : ((exp_valid && ready_i) ? 1'b0 : exp_valid);
         step();
      end
      n_cmp++; if (consumed != 6 || sb.size() != 0)
         begin n_bad++; $display("FAIL pulse_count: got consumed=%0d left=%0d want 6/0", consumed, sb.size()); end
      data_i = 16'hDCBA;
   endtask

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      rst    = 1'b1;
      req_i  = '0;
      ready_i = 1'b0;
      data_i = 16'hDCBA;             // requester n carries 4'hA + n
      test_reset();
      test_single();
      test_back_to_back();
      test_wrap();
      test_hold_stall();
      test_reset_in_hold();
      test_pulsed();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
